// File: rtl/debouncer_pkg.sv
// Shared definitions for the button/switch debouncer.
//   COUNT_W     : width of the stability counter exposed on `count`
//   last_count  : terminal value of the stability counter for a given
//                 number of consecutive disagreeing ticks
package debouncer_pkg;

    localparam int COUNT_W = 8;

    function automatic logic [COUNT_W-1:0] last_count(input int stable_ticks);
        return COUNT_W'(stable_ticks - 1);
    endfunction

endpackage

// File: rtl/debounce_tick_gen.sv
// Free-running prescaler that produces the debouncer sample tick.
// The counter runs 0..TICK_CYCLES-1 and wraps. It is never restarted by
// input activity.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   tick  : registered strobe, high for the one cycle in which the
//           prescaler equals TICK_CYCLES-1
module debounce_tick_gen #(
    parameter int TICK_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int PRE_W = $clog2(TICK_CYCLES);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_PENULT = PRE_W'(TICK_CYCLES - 2);

    logic [PRE_W-1:0] r_pre;
    logic             r_tick;

    // The strobe is registered one count early so that it is high exactly
    // while r_pre holds its terminal value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else begin
            if (r_pre == PRE_LAST) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
            r_tick <= (r_pre == PRE_PENULT);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/debouncer.sv
// Debounces one noisy asynchronous level input into a clean registered
// level. The input is synchronised through two flops, sampled on a slow
// prescaled tick, and `out` only follows it after the synchronised input
// has disagreed with `out` on STABLE_TICKS consecutive ticks.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset, clears all state
//   in    : raw asynchronous input level
//   out   : debounced level (registered)
//   chk   : one-cycle pulse on each sample tick (registered)
//   count : consecutive disagreeing ticks seen so far
module debouncer
    import debouncer_pkg::*;
#(
    parameter int TICK_CYCLES  = 50000,
    parameter int STABLE_TICKS = 20,
    parameter int CNT_W        = COUNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    output logic             out,
    output logic             chk,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(last_count(STABLE_TICKS));

    logic [1:0]       r_sync;
    logic             r_out;
    logic [CNT_W-1:0] r_count;
    logic             w_in_s;
    logic             w_tick;

    debounce_tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], in};
        end
    end

    assign w_in_s = r_sync[1];

    // Any agreeing cycle clears the count, even on a tick, so a single
    // cycle of agreement aborts a pending transition. The count stops at
    // CNT_LAST because that tick flips `out` and restarts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out   <= 1'b0;
            r_count <= '0;
        end else if (w_in_s == r_out) begin
            r_count <= '0;
        end else if (w_tick) begin
            if (r_count == CNT_LAST) begin
                r_out   <= w_in_s;
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign out   = r_out;
    assign chk   = w_tick;
    assign count = r_count;

endmodule

// File: tb/tb_debouncer.sv
// Scoreboard bench for the debouncer, run with TICK_CYCLES = 10 so that
// one "millisecond" is 10 clock cycles and the debounce time is 200 cycles.
module tb_debouncer;

    localparam int TICKS  = 10;
    localparam int STABLE = 20;
    localparam int LAT_MIN = (STABLE - 1) * TICKS + 2;
    localparam int LAT_MAX = STABLE * TICKS + 3;

    typedef struct {
        logic val;
        int   t0;
    } exp_t;

    logic       clk = 1'b1;
    logic       reset;
    logic       in;
    logic       out;
    logic       chk;
    logic [7:0] count;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   max_cnt = 0;
    logic prev_out = 1'b0;
    int   last_chk = -1;
    int   n_chk = 0;

    debouncer #(
        .TICK_CYCLES (TICKS),
        .STABLE_TICKS(STABLE),
        .CNT_W       (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .in   (in),
        .out  (out),
        .chk  (chk),
        .count(count)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input int act, input string req);
        checks++;
        if (ok) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d, required %s", name, act, req);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
    endtask

    task automatic expect_edge(input logic v);
        exp_t e;
        e.val = v;
        e.t0  = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Monitor: every edge on `out` outside reset must match the oldest
    // expected transition, in both value and latency window.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_out = out;
        end else if (out !== prev_out) begin
            prev_out = out;
            if (exp_q.size() == 0) begin
                check("unexpected_out_edge", 1'b0, int'(out), "no edge");
            end else begin
                e = exp_q.pop_front();
                check("out_edge_value", out === e.val, int'(out), $sformatf("%0d", e.val));
                check("out_edge_latency", (cyc - e.t0) >= LAT_MIN && (cyc - e.t0) <= LAT_MAX,
                      cyc - e.t0, $sformatf("%0d..%0d cycles", LAT_MIN, LAT_MAX));
            end
        end
    end

    // Tick spacing monitor.
    always @(negedge clk) begin
        if (reset) begin
            last_chk = -1;
        end else if (chk === 1'b1) begin
            if (last_chk >= 0 && n_chk < 8) begin
                n_chk++;
                check("chk_spacing", (cyc - last_chk) == TICKS, cyc - last_chk, "10");
            end
            last_chk = cyc;
        end
    end

    initial begin
        reset = 1'b1;
        in    = 1'b0;
        #25;
        check("reset_out", out === 1'b0, int'(out), "0");
        check("reset_chk", chk === 1'b0, int'(chk), "0");
        check("reset_count", count === 8'd0, int'(count), "0");
        @(negedge clk);
        reset = 1'b0;
        run(3);

        // 1: short pulse
        max_cnt = 0;
        in = 1'b1;
        run(5);
        in = 1'b0;
        run(40);
        check("pulse_max_count", max_cnt <= 1, max_cnt, "<=1");
        check("pulse_out", out === 1'b0, int'(out), "0");
        check("pulse_count_after", count === 8'd0, int'(count), "0");

        // 2: clean rise
        max_cnt = 0;
        in = 1'b1;
        expect_edge(1'b1);
        run(500);
        check("rise_out", out === 1'b1, int'(out), "1");
        check("rise_max_count", max_cnt == STABLE - 1, max_cnt, "19");
        check("rise_count_after", count === 8'd0, int'(count), "0");

        // 3: glitch low spanning one clock edge
        @(negedge clk);
        #2 in = 1'b0;
        #10 in = 1'b1;
        run(30);
        check("glitch_out", out === 1'b1, int'(out), "1");
        check("glitch_count", count === 8'd0, int'(count), "0");

        // 4: clean fall
        in = 1'b0;
        expect_edge(1'b0);
        run(500);
        check("fall_out", out === 1'b0, int'(out), "0");

        // 5: bounce train, then settle high
        for (int i = 0; i < 10; i++) begin
            in = (i % 2 == 0) ? 1'b1 : 1'b0;
            run(30);
        end
        check("bounce_out_before", out === 1'b0, int'(out), "0");
        in = 1'b1;
        expect_edge(1'b1);
        run(500);
        check("bounce_out_after", out === 1'b1, int'(out), "1");

        // 6: reset in the middle of a pending fall, with `in` going high
        in = 1'b0;
        run(100);
        check("pend_count", count >= 8'd8 && count <= 8'd10, int'(count), "8..10");
        check("pend_out", out === 1'b1, int'(out), "1");
        @(negedge clk);
        #3;
        in    = 1'b1;
        reset = 1'b1;
        #1;
        check("async_reset_out", out === 1'b0, int'(out), "0");
        check("async_reset_count", count === 8'd0, int'(count), "0");
        run(3);
        reset = 1'b0;
        expect_edge(1'b1);
        run(150);
        check("post_reset_out_held", out === 1'b0, int'(out), "0");
        run(150);
        check("post_reset_out", out === 1'b1, int'(out), "1");

        run(5);
        check("pending_expectations", exp_q.size() == 0, exp_q.size(), "0");
        check("chk_spacing_seen", n_chk == 8, n_chk, "8");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
